// File: rtl/cp0_defs.sv
// rtl/cp0_defs.sv - shared CP0 register selects, field positions and FSM state encoding
package cp0_defs;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int SR_IM_HI    = 15;
   localparam int SR_IM_LO    = 10;
   localparam int SR_EXL      = 1;
   localparam int SR_IE       = 0;
   localparam int CAUSE_IP_HI = 15;
   localparam int CAUSE_IP_LO = 10;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_SVC = 1'b1
   } cp0_state_e;

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// rtl/cp0_irq_ctrl_if.sv - pipeline/device side signal bundle of the CP0 interrupt controller
interface cp0_irq_ctrl_if;

   logic [5:0]  HWInt;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] PC;
   logic        IntAck;
   logic        Eret;
   logic        IntReq;
   logic [31:0] EPC;
   logic [31:0] DOut;

   // pipeline and devices drive requests, accesses and events
   modport master (
      output HWInt, A1, A2, DIn, WE, PC, IntAck, Eret,
      input  IntReq, EPC, DOut
   );

   // CP0 consumes them and answers with IntReq, EPC and read data
   modport slave (
      input  HWInt, A1, A2, DIn, WE, PC, IntAck, Eret,
      output IntReq, EPC, DOut
   );

endinterface

// File: rtl/cp0_irq_sync.sv
// rtl/cp0_irq_sync.sv - IP sampling register for the six hardware interrupt lines
module cp0_irq_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] hwint_i,
   output logic [5:0] ip_o
);

   logic [5:0] ip_d;
   logic [5:0] ip_q;

   // IP tracks the line level, no sticky latch
   always_comb begin
      ip_d = hwint_i;
   end

   // single sampling stage; a synchronizer chain can replace it for foreign clock domains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ip_q <= '0;
      end else begin
         ip_q <= ip_d;
      end
   end

   assign ip_o = ip_q;

endmodule

// File: rtl/cp0_irq_ctrl.sv
// rtl/cp0_irq_ctrl.sv - CP0 interrupt controller: SR/Cause/EPC/PRId, IntReq and EPC capture/return
module cp0_irq_ctrl
   import cp0_defs::*;
#(
   parameter logic [31:0] PRID_VAL  = 32'h0000_2333,
   parameter logic [31:0] EPC_RESET = 32'h0000_3000
) (
   input  logic           clk,
   input  logic           reset_n,
   cp0_irq_ctrl_if.slave  cp
);

   logic [5:0]  ip;
   logic [5:0]  im_d, im_q;
   logic        ie_d, ie_q;
   logic [31:0] epc_d, epc_q;
   cp0_state_e  state_d, state_q;
   logic        exl;
   logic        int_req;
   logic        wr_sr;
   logic        wr_epc;
   logic        unused_ok;

   cp0_irq_sync u_sync (
      .clk     (clk),
      .rst_n   (reset_n),
      .hwint_i (cp.HWInt),
      .ip_o    (ip)
   );

   // EXL is the state itself, so the two can never disagree
   assign exl     = (state_q == ST_SVC);
   assign int_req = (state_q == ST_RUN) & ie_q & (|(ip & im_q));
   assign wr_sr   = cp.WE & (cp.A2 == CP0_SR);
   assign wr_epc  = cp.WE & (cp.A2 == CP0_EPC);

   // next state: mtc0 first, then Eret, then IntAck, so later assignments take priority
   always_comb begin
      im_d    = im_q;
      ie_d    = ie_q;
      epc_d   = epc_q;
      state_d = state_q;
      if (wr_sr) begin
         im_d    = cp.DIn[SR_IM_HI:SR_IM_LO];
         ie_d    = cp.DIn[SR_IE];
         state_d = cp.DIn[SR_EXL] ? ST_SVC : ST_RUN;
      end
      if (wr_epc) begin
         epc_d = cp.DIn;
      end
      if (cp.Eret && state_q == ST_SVC) begin
         state_d = ST_RUN;
      end
      if (cp.IntAck && int_req) begin
         epc_d   = {cp.PC[31:2], 2'b00};
         state_d = ST_SVC;
      end
   end

   // SR, EPC and FSM state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         im_q    <= '0;
         ie_q    <= 1'b0;
         epc_q   <= EPC_RESET;
         state_q <= ST_RUN;
      end else begin
         im_q    <= im_d;
         ie_q    <= ie_d;
         epc_q   <= epc_d;
         state_q <= state_d;
      end
   end

   // mfc0 read mux, unknown selects read as zero
   always_comb begin
      cp.DOut = 32'h0;
      case (cp.A1)
         CP0_SR: begin
            cp.DOut[SR_IM_HI:SR_IM_LO] = im_q;
            cp.DOut[SR_EXL]            = exl;
            cp.DOut[SR_IE]             = ie_q;
         end
         CP0_CAUSE: cp.DOut[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
         CP0_EPC:   cp.DOut = epc_q;
         CP0_PRID:  cp.DOut = PRID_VAL;
         default:   cp.DOut = 32'h0;
      endcase
   end

   assign cp.IntReq = int_req;
   assign cp.EPC    = epc_q;

   // PC low bits and unimplemented SR bits are intentionally dropped
   assign unused_ok = ^{cp.PC[1:0], cp.DIn[31:16], cp.DIn[9:2]};

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// tb/tb_cp0_irq_ctrl.sv - scoreboard testbench for cp0_irq_ctrl
module tb_cp0_irq_ctrl;

   localparam int K_IRQ  = 0;
   localparam int K_EPC  = 1;
   localparam int K_DOUT = 2;

   typedef struct {
      int          kind;
      string       name;
      logic [31:0] exp;
   } chk_t;

   logic clk;
   logic reset_n;
   int   n_tests;
   int   n_fail;
   int   tc_count;
   chk_t sb_q[$];

   cp0_irq_ctrl_if cif ();

   cp0_irq_ctrl #(
      .PRID_VAL  (32'h0000_2333),
      .EPC_RESET (32'h0000_3000)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cp      (cif.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, queue size %0d required 0", sb_q.size());
      $fatal(1, "watchdog");
   end

   // monitor: compare every queued expectation against the DUT at the falling edge
   always @(negedge clk) begin
      logic [31:0] act;
      chk_t        c;
      while (sb_q.size() > 0) begin
         c = sb_q.pop_front();
         case (c.kind)
            K_IRQ:   act = {31'b0, cif.IntReq};
            K_EPC:   act = cif.EPC;
            default: act = cif.DOut;
         endcase
         n_tests++;
         if (act !== c.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input int kind, input logic [4:0] a1, input string name, input logic [31:0] exp);
      chk_t c;
      if (kind == K_DOUT) cif.A1 = a1;
      c.kind = kind;
      c.name = name;
      c.exp  = exp;
      sb_q.push_back(c);
   endtask

   task automatic mtc0(input logic [4:0] sel, input logic [31:0] data);
      cif.WE  = 1'b1;
      cif.A2  = sel;
      cif.DIn = data;
      tick();
      cif.WE  = 1'b0;
   endtask

   task automatic clr_ev();
      cif.WE     = 1'b0;
      cif.IntAck = 1'b0;
      cif.Eret   = 1'b0;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      cif.HWInt  = 6'b0;
      cif.A1     = 5'd0;
      cif.A2     = 5'd0;
      cif.DIn    = 32'h0;
      cif.WE     = 1'b0;
      cif.PC     = 32'h0;
      cif.IntAck = 1'b0;
      cif.Eret   = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      chk(K_IRQ, 0, "reset_irq", 32'h0);
      chk(K_EPC, 0, "reset_epc", 32'h3000);
      chk(K_DOUT, 12, "reset_sr", 32'h0);
      tick();

      // T1: async reset mid-run
      mtc0(12, 32'h0000_0401);
      mtc0(14, 32'h0000_5000);
      cif.HWInt = 6'b000001;
      tick();
      chk(K_IRQ, 0, "pre_reset_irq", 32'h1);
      tick();
      reset_n = 1'b0;
      chk(K_IRQ, 0, "async_rst_irq", 32'h0);
      chk(K_EPC, 0, "async_rst_epc", 32'h3000);
      chk(K_DOUT, 12, "async_rst_sr", 32'h0);
      cif.HWInt = 6'b0;
      tick();
      reset_n = 1'b1;
      tick();

      // T2: basic request and acknowledge
      mtc0(12, 32'h0000_0401);
      cif.HWInt = 6'b000001;
      chk(K_IRQ, 0, "irq_before_sample", 32'h0);
      tick();
      chk(K_IRQ, 0, "irq_one_cycle", 32'h1);
      cif.IntAck = 1'b1;
      cif.PC     = 32'h0000_3010;
      tick();
      clr_ev();
      chk(K_EPC, 0, "ack_epc", 32'h3010);
      chk(K_IRQ, 0, "ack_irq_low", 32'h0);
      chk(K_DOUT, 12, "ack_sr", 32'h0000_0403);
      tick();
      chk(K_DOUT, 13, "cause_ip", 32'h0000_0400);
      tick();

      // T4: return with line still high, then drop it
      cif.Eret = 1'b1;
      tick();
      clr_ev();
      chk(K_DOUT, 12, "eret_sr", 32'h0000_0401);
      chk(K_IRQ, 0, "eret_repend", 32'h1);
      cif.HWInt = 6'b0;
      tick();
      chk(K_IRQ, 0, "line_drop", 32'h0);

      // IntAck with no request and Eret in RUN are ignored
      cif.IntAck = 1'b1;
      cif.PC     = 32'h0000_7770;
      tick();
      clr_ev();
      chk(K_EPC, 0, "ack_no_req_epc", 32'h3010);
      chk(K_DOUT, 12, "ack_no_req_sr", 32'h0000_0401);
      cif.Eret = 1'b1;
      tick();
      clr_ev();
      chk(K_DOUT, 12, "eret_in_run", 32'h0000_0401);

      // T3: masking
      mtc0(12, 32'h0000_0801);
      cif.HWInt = 6'b000001;
      repeat (2) tick();
      chk(K_IRQ, 0, "masked_irq", 32'h0);
      chk(K_DOUT, 13, "masked_cause", 32'h0000_0400);
      tick();

      // mtc0 latency: read in the write cycle sees the old value
      cif.WE  = 1'b1;
      cif.A2  = 5'd12;
      cif.DIn = 32'hFFFF_FFFF;
      chk(K_DOUT, 12, "mtc0_old", 32'h0000_0801);
      tick();
      clr_ev();
      chk(K_DOUT, 12, "mtc0_new", 32'h0000_FC03);
      chk(K_IRQ, 0, "exl_blocks_irq", 32'h0);
      tick();

      // T5: Eret + mtc0 SR
      cif.Eret = 1'b1;
      cif.WE   = 1'b1;
      cif.A2   = 5'd12;
      cif.DIn  = 32'h0000_FC03;
      tick();
      clr_ev();
      chk(K_DOUT, 12, "eret_vs_mtc0_sr", 32'h0000_FC01);
      chk(K_IRQ, 0, "eret_vs_mtc0_irq", 32'h1);

      // T5: IntAck + mtc0 EPC, unaligned PC
      cif.IntAck = 1'b1;
      cif.PC     = 32'h0000_3127;
      cif.WE     = 1'b1;
      cif.A2     = 5'd14;
      cif.DIn    = 32'h0000_4000;
      tick();
      clr_ev();
      chk(K_EPC, 0, "ack_vs_mtc0_epc", 32'h3124);
      chk(K_IRQ, 0, "ack_vs_mtc0_irq", 32'h0);
      chk(K_DOUT, 12, "ack_vs_mtc0_sr", 32'h0000_FC03);
      tick();

      // IntAck in SVC is ignored, the EPC write goes through
      cif.IntAck = 1'b1;
      cif.PC     = 32'h0000_8888;
      cif.WE     = 1'b1;
      cif.A2     = 5'd14;
      cif.DIn    = 32'h0000_4000;
      tick();
      clr_ev();
      chk(K_EPC, 0, "nest_ignored_epc", 32'h4000);
      chk(K_DOUT, 12, "nest_ignored_sr", 32'h0000_FC03);
      cif.Eret = 1'b1;
      tick();
      clr_ev();
      chk(K_IRQ, 0, "back_to_run_irq", 32'h1);

      // IntAck + mtc0 SR: EXL set wins, IM/IE from DIn
      cif.IntAck = 1'b1;
      cif.PC     = 32'h0000_3200;
      cif.WE     = 1'b1;
      cif.A2     = 5'd12;
      cif.DIn    = 32'h0000_0400;
      tick();
      clr_ev();
      chk(K_DOUT, 12, "ack_vs_mtc0_sr2", 32'h0000_0402);
      chk(K_EPC, 0, "ack_vs_mtc0_sr_epc", 32'h3200);

      // dropped writes and read-only / unknown selects
      mtc0(13, 32'hFFFF_FFFF);
      chk(K_DOUT, 13, "cause_ro", 32'h0000_0400);
      tick();
      mtc0(15, 32'h0);
      chk(K_DOUT, 15, "prid", 32'h0000_2333);
      tick();
      chk(K_DOUT, 5, "unknown_sel", 32'h0);
      tick();

      // reset while in SVC
      reset_n = 1'b0;
      chk(K_IRQ, 0, "svc_rst_irq", 32'h0);
      chk(K_EPC, 0, "svc_rst_epc", 32'h3000);
      chk(K_DOUT, 12, "svc_rst_sr", 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      chk(K_IRQ, 0, "svc_rst_req_lost", 32'h0);
      chk(K_DOUT, 13, "svc_rst_ip_back", 32'h0000_0400);
      cif.HWInt = 6'b0;
      tick();

      // T6: timer mode 0, preset 3, Ctrl=1001 drives HWInt[0] when Count hits 0
      mtc0(12, 32'h0000_0401);
      tc_count = 3;
      for (int i = 0; i < 3; i++) begin
         tick();
         tc_count--;
         if (tc_count == 0) cif.HWInt[0] = 1'b1;
         chk(K_IRQ, 0, "tc_counting", 32'h0);
      end
      tick();
      chk(K_IRQ, 0, "tc_irq", 32'h1);
      cif.HWInt[0] = 1'b0;
      chk(K_IRQ, 0, "tc_irq_hold", 32'h1);
      tick();
      chk(K_IRQ, 0, "tc_clear", 32'h0);
      tick();
      tick();

      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
